dispense_sequencer: RTL and testbench

//  Sequences one candy dispense per Raspberry Pi request: spins DC agitator up, issues an exact stepper pulse count
//  for the requested amount, settles, then returns a level handshake to the Pi. Sits between the Pi GPIO inputs
//  (request, amount) and the stepper/DC motor driver pins; the DC PWM waveform itself is generated upstream and gated here.

---
 rtl/dispense_pkg.sv | 47 ++++
 rtl/step_pulse_gen.sv | 70 +++++++
 rtl/dispense_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispense_pkg
// Description : Shared types and constants for the candy dispense sequencer.
//               Holds the sequencer state encoding, the amount codes sent by
//               the Pi, the DC H-bridge idle/run encodings and small helpers.
//               With DISPENSE_TIMEOUT_EN defined, the FAULT state also exists.
// Revision    : 1.0 - initial release
// ============================================================================
package dispense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPINUP = 3'd1,
        ST_STEP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
`ifdef DISPENSE_TIMEOUT_EN
        ,
        ST_FAULT  = 3'd6
`endif
    } state_t;

    // Amount codes presented by the Pi
    localparam logic [1:0] AMT_SMALL   = 2'b00;
    localparam logic [1:0] AMT_MED     = 2'b01;
    localparam logic [1:0] AMT_LARGE   = 2'b10;
    localparam logic [1:0] AMT_INVALID = 2'b11;

    // DC H-bridge encodings as {IN1, IN2}
    localparam logic [1:0] MOTOR_IDLE = 2'b01;
    localparam logic [1:0] MOTOR_RUN  = 2'b10;

    // States in which the agitator motor spins and busy is reported
    function automatic logic is_running(input state_t s);
        return (s == ST_SPINUP) || (s == ST_STEP) || (s == ST_SETTLE);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen
// Description : Stepper pulse timing. While i_start is high, a period counter
//               runs 0..STEP_DIV-1 and a pulse counter advances at each period
//               wrap. o_done pulses in the last cycle of the i_target-th
//               period. Both counters clear whenever i_start is low.
//               o_step_nxt is the step level for the cycle following the
//               coming clock edge, so the parent can register step_o in step
//               with its own next-state decode.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - run enable (parent is in its STEP state)
//               i_target        - number of step pulses to issue
//               o_step_nxt      - step level for next cycle
//               o_done          - final cycle of the last period
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_gen #(
    parameter int STEP_DIV  = 4000,
    parameter int STEP_HIGH = 2000,
    parameter int TGT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [TGT_W-1:0] i_target,
    output logic             o_step_nxt,
    output logic             o_done
);

    localparam int                 c_PER_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(STEP_DIV - 1);
    localparam logic [c_PER_W-1:0] c_HIGH     = c_PER_W'(STEP_HIGH);
    localparam logic [c_PER_W-1:0] c_PER_ONE  = c_PER_W'(1);
    localparam logic [TGT_W-1:0]   c_TGT_ONE  = TGT_W'(1);

    logic [c_PER_W-1:0] r_period_q;
    logic [c_PER_W-1:0] w_period_d;
    logic [TGT_W-1:0]   r_pulse_q;
    logic [TGT_W-1:0]   w_pulse_d;
    logic               w_wrap;

    always_comb begin
        w_wrap     = i_start && (r_period_q == c_PER_LAST);
        o_done     = w_wrap && (r_pulse_q == (i_target - c_TGT_ONE));
        w_period_d = '0;
        w_pulse_d  = '0;
        if (i_start && !w_wrap) begin
            w_period_d = r_period_q + c_PER_ONE;
            w_pulse_d  = r_pulse_q;
        end else if (w_wrap && !o_done) begin
            // New period starts at 0; pulse count stops at target, never wraps
            w_pulse_d = r_pulse_q + c_TGT_ONE;
        end
        // Entering or continuing a run, the next period index is w_period_d
        o_step_nxt = (w_period_d < c_HIGH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_q <= '0;
            r_pulse_q  <= '0;
        end else begin
            r_period_q <= w_period_d;
            r_pulse_q  <= w_pulse_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dispense_sequencer
// Description : Runs one candy dispense per Pi request: DC agitator spin-up,
//               an exact number of stepper pulses for the requested amount,
//               a settle period, then a level handshake back to the Pi.
//               Optional feature macro: DISPENSE_TIMEOUT_EN - a handshake left
//               high for TIMEOUT_CYC cycles moves to FAULT (err_o=1).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               candy_req     - async level request from the Pi
//               amount        - async amount code, taken on acceptance
//               dc_pwm_i      - upstream DC PWM waveform
//               step_o        - stepper step pulse
//               step_dir_o    - stepper direction (fixed dispense direction)
//               dc_in1_o/in2  - DC H-bridge inputs
//               dc_pwm_o      - gated DC PWM enable
//               handshake_o   - dispense complete
//               busy_o        - sequence in progress
//               err_o         - invalid amount or fault
// Revision    : 1.0 - initial release
// ============================================================================
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int STEP_DIV    = 4000,
    parameter int STEP_HIGH   = 2000,
    parameter int STEPS_SMALL = 200,
    parameter int STEPS_MED   = 400,
    parameter int STEPS_LARGE = 600,
    parameter int SPINUP_CYC  = 208000,
    parameter int SETTLE_CYC  = 104000,
    parameter int TIMEOUT_CYC = 2080000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       candy_req,
    input  logic [1:0] amount,
    input  logic       dc_pwm_i,
    output logic       step_o,
    output logic       step_dir_o,
    output logic       dc_in1_o,
    output logic       dc_in2_o,
    output logic       dc_pwm_o,
    output logic       handshake_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int c_TGT_W  = $clog2(max3(STEPS_SMALL, STEPS_MED, STEPS_LARGE) + 1);
    localparam int c_PH_W   = $clog2(max3(SPINUP_CYC, SETTLE_CYC, TIMEOUT_CYC) + 1);

    localparam logic [c_TGT_W-1:0] c_TGT_SMALL   = c_TGT_W'(STEPS_SMALL);
    localparam logic [c_TGT_W-1:0] c_TGT_MED     = c_TGT_W'(STEPS_MED);
    localparam logic [c_TGT_W-1:0] c_TGT_LARGE   = c_TGT_W'(STEPS_LARGE);
    localparam logic [c_PH_W-1:0]  c_SPIN_LAST   = c_PH_W'(SPINUP_CYC - 1);
    localparam logic [c_PH_W-1:0]  c_SETTLE_LAST = c_PH_W'(SETTLE_CYC - 1);
    localparam logic [c_PH_W-1:0]  c_PH_ONE      = c_PH_W'(1);
`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [c_PH_W-1:0]  c_TO_LAST     = c_PH_W'(TIMEOUT_CYC - 1);
`endif

    // Synchronizers
    logic       r_req_meta_q;
    logic       r_req_s_q;
    logic [1:0] r_amt_meta_q;
    logic [1:0] r_amt_s_q;

    // Sequencer state and counters
    state_t             r_state_q;
    state_t             w_state_d;
    logic [c_PH_W-1:0]  r_phase_q;
    logic [c_PH_W-1:0]  w_phase_d;
    logic [c_TGT_W-1:0] r_target_q;
    logic [c_TGT_W-1:0] w_target_d;

    // Registered outputs
    logic r_step_q,   w_step_d;
    logic r_dc_in1_q, w_dc_in1_d;
    logic r_dc_in2_q, w_dc_in2_d;
    logic r_pwm_en_q, w_pwm_en_d;
    logic r_hs_q,     w_hs_d;
    logic r_busy_q,   w_busy_d;
    logic r_err_q,    w_err_d;

    logic       w_step_nxt;
    logic       w_step_done;
    logic       w_run;
    logic [1:0] w_motor;

    step_pulse_gen #(
        .STEP_DIV  (STEP_DIV),
        .STEP_HIGH (STEP_HIGH),
        .TGT_W     (c_TGT_W)
    ) u_step_gen (
        .clk        (clk),
        .rst        (rst),
        .i_start    (r_state_q == ST_STEP),
        .i_target   (r_target_q),
        .o_step_nxt (w_step_nxt),
        .o_done     (w_step_done)
    );

    // Next-state logic. The phase counter clears on every state change and
    // times SPINUP, SETTLE and (optionally) the DONE dwell.
    always_comb begin
        w_state_d  = r_state_q;
        w_phase_d  = '0;
        w_target_d = r_target_q;
        case (r_state_q)
            ST_IDLE: begin
                if (r_req_s_q) begin
                    case (r_amt_s_q)
                        AMT_SMALL: begin w_target_d = c_TGT_SMALL; w_state_d = ST_SPINUP; end
                        AMT_MED:   begin w_target_d = c_TGT_MED;   w_state_d = ST_SPINUP; end
                        AMT_LARGE: begin w_target_d = c_TGT_LARGE; w_state_d = ST_SPINUP; end
                        default:   w_state_d = ST_ERROR;
                    endcase
                end
            end
            ST_SPINUP: begin
                if (!r_req_s_q)                    w_state_d = ST_IDLE;
                else if (r_phase_q == c_SPIN_LAST) w_state_d = ST_STEP;
                else                               w_phase_d = r_phase_q + c_PH_ONE;
            end
            ST_STEP: begin
                if (!r_req_s_q)       w_state_d = ST_IDLE;
                else if (w_step_done) w_state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!r_req_s_q)                      w_state_d = ST_IDLE;
                else if (r_phase_q == c_SETTLE_LAST) w_state_d = ST_DONE;
                else                                 w_phase_d = r_phase_q + c_PH_ONE;
            end
            ST_DONE: begin
                if (!r_req_s_q)                  w_state_d = ST_IDLE;
`ifdef DISPENSE_TIMEOUT_EN
                else if (r_phase_q == c_TO_LAST) w_state_d = ST_FAULT;
                else                             w_phase_d = r_phase_q + c_PH_ONE;
`endif
            end
            ST_ERROR: begin
                if (!r_req_s_q) w_state_d = ST_IDLE;
            end
`ifdef DISPENSE_TIMEOUT_EN
            ST_FAULT: begin
                if (!r_req_s_q) w_state_d = ST_IDLE;
            end
`endif
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they are registered alongside it
    always_comb begin
        w_run      = is_running(w_state_d);
        w_motor    = w_run ? MOTOR_RUN : MOTOR_IDLE;
        w_dc_in1_d = w_motor[1];
        w_dc_in2_d = w_motor[0];
        w_pwm_en_d = w_run;
        w_busy_d   = w_run;
        w_step_d   = (w_state_d == ST_STEP) && w_step_nxt;
        w_hs_d     = (w_state_d == ST_DONE);
`ifdef DISPENSE_TIMEOUT_EN
        w_err_d    = (w_state_d == ST_ERROR) || (w_state_d == ST_FAULT);
`else
        w_err_d    = (w_state_d == ST_ERROR);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_meta_q <= 1'b0;
            r_req_s_q    <= 1'b0;
            r_amt_meta_q <= 2'b00;
            r_amt_s_q    <= 2'b00;
            r_state_q    <= ST_IDLE;
            r_phase_q    <= '0;
            r_target_q   <= '0;
            r_step_q     <= 1'b0;
            r_dc_in1_q   <= MOTOR_IDLE[1];
            r_dc_in2_q   <= MOTOR_IDLE[0];
            r_pwm_en_q   <= 1'b0;
            r_hs_q       <= 1'b0;
            r_busy_q     <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            // Two-flop synchronizers for the asynchronous Pi inputs
            r_req_meta_q <= candy_req;
            r_req_s_q    <= r_req_meta_q;
            r_amt_meta_q <= amount;
            r_amt_s_q    <= r_amt_meta_q;
            r_state_q    <= w_state_d;
            r_phase_q    <= w_phase_d;
            r_target_q   <= w_target_d;
            r_step_q     <= w_step_d;
            r_dc_in1_q   <= w_dc_in1_d;
            r_dc_in2_q   <= w_dc_in2_d;
            r_pwm_en_q   <= w_pwm_en_d;
            r_hs_q       <= w_hs_d;
            r_busy_q     <= w_busy_d;
            r_err_q      <= w_err_d;
        end
    end

    assign step_o      = r_step_q;
    assign step_dir_o  = 1'b0;
    assign dc_in1_o    = r_dc_in1_q;
    assign dc_in2_o    = r_dc_in2_q;
    assign dc_pwm_o    = r_pwm_en_q & dc_pwm_i;
    assign handshake_o = r_hs_q;
    assign busy_o      = r_busy_q;
    assign err_o       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispense_sequencer
// Description : Directed self-checking bench for dispense_sequencer with
//               shortened timing (STEP_DIV=8, STEP_HIGH=4, steps 3/5/7,
//               SPINUP=5, SETTLE=4, TIMEOUT=20). Honours DISPENSE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispense_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       candy_req = 1'b0;
    logic [1:0] amount = 2'b00;
    logic       dc_pwm_i;
    logic       step_o, step_dir_o, dc_in1_o, dc_in2_o, dc_pwm_o;
    logic       handshake_o, busy_o, err_o;

    int checks = 0;
    int errors = 0;

    // Output activity monitor, sampled on the falling edge
    logic       mon_clr = 1'b0;
    logic       prev_step = 1'b0;
    int         n_rise = 0, n_hi = 0, n_run = 0, n_pwm = 0, n_pwm_bad = 0;
    logic       hs_seen = 1'b0;
    logic [1:0] pwm_div = 2'b00;

    always #5 clk = ~clk;

    always @(posedge clk) pwm_div <= pwm_div + 2'd1;
    assign dc_pwm_i = pwm_div[1];

    dispense_sequencer #(
        .STEP_DIV    (8),
        .STEP_HIGH   (4),
        .STEPS_SMALL (3),
        .STEPS_MED   (5),
        .STEPS_LARGE (7),
        .SPINUP_CYC  (5),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .candy_req   (candy_req),
        .amount      (amount),
        .dc_pwm_i    (dc_pwm_i),
        .step_o      (step_o),
        .step_dir_o  (step_dir_o),
        .dc_in1_o    (dc_in1_o),
        .dc_in2_o    (dc_in2_o),
        .dc_pwm_o    (dc_pwm_o),
        .handshake_o (handshake_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always @(negedge clk) begin
        if (dc_pwm_o && !dc_in1_o) n_pwm_bad <= n_pwm_bad + 1;
        if (mon_clr) begin
            prev_step <= 1'b0;
            n_rise    <= 0;
            n_hi      <= 0;
            n_run     <= 0;
            n_pwm     <= 0;
            hs_seen   <= 1'b0;
        end else begin
            prev_step <= step_o;
            if (step_o && !prev_step)   n_rise  <= n_rise + 1;
            if (step_o)                 n_hi    <= n_hi + 1;
            if (dc_in1_o && !dc_in2_o)  n_run   <= n_run + 1;
            if (dc_pwm_o)               n_pwm   <= n_pwm + 1;
            if (handshake_o)            hs_seen <= 1'b1;
        end
    end

    // {step, dir, in1, in2, pwm, handshake, busy, err}
    function automatic logic [7:0] outs();
        return {step_o, step_dir_o, dc_in1_o, dc_in2_o, dc_pwm_o, handshake_o, busy_o, err_o};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return handshake_o;
            1:       return err_o;
            default: return busy_o;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Bounded wait for sig(sel)==lvl; the outcome is itself a comparison
    task automatic wait_sig(input string tag, input int sel, input logic lvl, input int budget);
        int n = 0;
        while (sig(sel) !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, sig(sel)}, {31'd0, lvl});
    endtask

    task automatic wait_rise(input string tag, input int k, input int budget);
        int n = 0;
        while (n_rise < k && n < budget) begin
            tick();
            n++;
        end
        check(tag, n_rise, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("reset_outputs", {24'd0, outs()}, 32'h10);
        rst = 1'b0;
        tick();
        check("idle_outputs", {24'd0, outs()}, 32'h10);

        // 1: small amount, full sequence
        clr_mon();
        amount = 2'b00;
        candy_req = 1'b1;
        wait_sig("t1_handshake_high", 0, 1'b1, 100);
        check("t1_pulses", n_rise, 3);
        check("t1_step_high_cycles", n_hi, 12);
        check("t1_dc_run_cycles", n_run, 33);
        check("t1_pwm_passed", {31'd0, n_pwm > 0}, 1);
        check("t1_done_outputs", {24'd0, outs()}, 32'h14);
        candy_req = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        check("t1_handshake_drop", {31'd0, handshake_o}, 0);

        // 2: medium, amount change after acceptance ignored, then large
        clr_mon();
        amount = 2'b01;
        candy_req = 1'b1;
        wait_sig("t2_busy", 2, 1'b1, 20);
        amount = 2'b10;
        wait_sig("t2a_handshake_high", 0, 1'b1, 150);
        check("t2a_pulses", n_rise, 5);
        check("t2a_dc_run_cycles", n_run, 49);
        repeat (10) tick();
        check("t2_not_reaccepted", {24'd0, outs()}, 32'h14);
        check("t2_no_extra_pulses", n_rise, 5);
        candy_req = 1'b0;
        wait_sig("t2_handshake_clear", 0, 1'b0, 10);
        clr_mon();
        candy_req = 1'b1;
        wait_sig("t2b_handshake_high", 0, 1'b1, 150);
        check("t2b_pulses", n_rise, 7);
        check("t2b_step_high_cycles", n_hi, 28);
        candy_req = 1'b0;
        wait_sig("t2b_handshake_clear", 0, 1'b0, 10);

        // 3: invalid amount
        clr_mon();
        amount = 2'b11;
        candy_req = 1'b1;
        wait_sig("t3_err_high", 1, 1'b1, 10);
        repeat (5) tick();
        check("t3_error_outputs", {24'd0, outs()}, 32'h11);
        check("t3_no_pulses", n_rise, 0);
        check("t3_no_pwm", n_pwm, 0);
        candy_req = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        check("t3_err_clear", {24'd0, outs()}, 32'h10);

        // 4: abort after second pulse
        clr_mon();
        amount = 2'b10;
        candy_req = 1'b1;
        wait_rise("t4_second_pulse", 2, 100);
        candy_req = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        check("t4_abort_outputs", {24'd0, outs()}, 32'h10);
        repeat (10) tick();
        check("t4_no_handshake", {31'd0, hs_seen}, 0);
        check("t4_pulses_stopped", n_rise, 2);

        // 5: reset mid-STEP, then a clean request
        clr_mon();
        amount = 2'b00;
        candy_req = 1'b1;
        wait_rise("t5_first_pulse", 1, 100);
        rst = 1'b1;
        candy_req = 1'b0;
        tick();
        check("t5_reset_outputs", {24'd0, outs()}, 32'h10);
        rst = 1'b0;
        tick();
        clr_mon();
        candy_req = 1'b1;
        wait_sig("t5_handshake_high", 0, 1'b1, 100);
        check("t5_pulses", n_rise, 3);

        // 6: handshake dwell with request still high
        repeat (25) tick();
`ifdef DISPENSE_TIMEOUT_EN
        check("t6_fault_outputs", {24'd0, outs()}, 32'h11);
`else
        check("t6_handshake_held", {24'd0, outs()}, 32'h14);
`endif
        candy_req = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        check("t6_release", {24'd0, outs()}, 32'h10);

        check("pwm_only_when_running", n_pwm_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
